// File: rtl/spiking_neuron_nin.sv
// N-input spiking neuron: kernel-weighted synaptic sum against a runtime barrier,
// optional delayed spike delivery, and a saturating output spike counter.
module spiking_neuron_nin #(
    parameter int NEURON_ID           = 0,
    parameter int INPUTS_COUNT        = 4,
    parameter int ADDR_WIDTH          = 8,
    parameter int CMD_WIDTH           = 8,
    parameter int INT_WIDTH           = 8,
    parameter int OUT_BARRIER         = (2**INT_WIDTH - 1) / 2,
    parameter int COMPENSATION_WEIGHT = (2**INT_WIDTH - 1) * INPUTS_COUNT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [CMD_WIDTH-1:0]    cmd,
    input  logic [2*INT_WIDTH-1:0]  cmd_arg,
    input  logic [INPUTS_COUNT-1:0] in_bus,
    output logic                    out,
    output logic [INT_WIDTH-1:0]    spike_count
);

    localparam int INT_MAX = 2**INT_WIDTH - 1;
    localparam int WW      = 2 * INT_WIDTH;
    localparam int ACC_W   = 3 * INT_WIDTH + $clog2(INPUTS_COUNT + 2) + 1;

    localparam logic [3:0]           AGE_NULL    = 4'd15;
    localparam logic [CMD_WIDTH-1:0] CMD_CLEAR   = CMD_WIDTH'(2**CMD_WIDTH - 3);
    localparam logic [CMD_WIDTH-1:0] CMD_DELIV   = CMD_WIDTH'(INPUTS_COUNT + 1);
    localparam logic [CMD_WIDTH-1:0] CMD_BIAS    = CMD_WIDTH'(INPUTS_COUNT + 2);
    localparam logic [CMD_WIDTH-1:0] CMD_BARRIER = CMD_WIDTH'(INPUTS_COUNT + 3);
    localparam logic signed [ACC_W-1:0] COMP_W   = ACC_W'(COMPENSATION_WEIGHT);

    logic signed [WW-1:0]     weight [INPUTS_COUNT];
    logic signed [WW-1:0]     bias;
    logic [INT_WIDTH-1:0]     delivery_time;
    logic [INT_WIDTH-1:0]     barrier;
    logic [INT_WIDTH-1:0]     delivery_cnt;
    logic [3:0]               age [INPUTS_COUNT];
    logic [3:0]               age_out;

    logic [3:0]               age_adv [INPUTS_COUNT];
    logic [3:0]               age_out_adv;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  k_ext;
    logic signed [ACC_W-1:0]  w_ext;
    logic [INT_WIDTH-1:0]     norm;
    logic                     fire;

    function automatic logic [INT_WIDTH-1:0] kernel(input logic [3:0] a);
        case (a)
            4'd0:    kernel = INT_WIDTH'(INT_MAX * 7 / 10);
            4'd1:    kernel = INT_WIDTH'(INT_MAX);
            4'd2:    kernel = INT_WIDTH'(INT_MAX * 6 / 10);
            4'd3:    kernel = INT_WIDTH'(INT_MAX * 3 / 10);
            4'd4:    kernel = INT_WIDTH'(INT_MAX / 10);
            default: kernel = '0;
        endcase
    endfunction

    function automatic logic [3:0] next_age(input logic [3:0] a);
        next_age = (a < 4'd4) ? a + 4'd1 : AGE_NULL;
    endfunction

    // Evaluation uses the ages as advanced by this same tick.
    always_comb begin
        age_out_adv = next_age(age_out);
        for (int unsigned i = 0; i < INPUTS_COUNT; i++) begin
            age_adv[i] = in_bus[i] ? 4'd0 : next_age(age[i]);
        end
        k_ext = ACC_W'(kernel(age_out_adv));
        acc   = {{(ACC_W - WW){bias[WW-1]}}, bias} <<< INT_WIDTH;
        acc   = acc - k_ext * COMP_W;
        for (int unsigned i = 0; i < INPUTS_COUNT; i++) begin
            k_ext = ACC_W'(kernel(age_adv[i]));
            w_ext = {{(ACC_W - WW){weight[i][WW-1]}}, weight[i]};
            acc   = acc + k_ext * w_ext;
        end
        if (acc[ACC_W-1]) begin
            norm = '0;
        end else if (|acc[ACC_W-2:2*INT_WIDTH]) begin
            norm = '1;
        end else begin
            norm = acc[2*INT_WIDTH-1:INT_WIDTH];
        end
        fire = norm > barrier;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < INPUTS_COUNT; i++) begin
                weight[i] <= WW'(INT_MAX / INPUTS_COUNT);
                age[i]    <= AGE_NULL;
            end
            bias          <= '0;
            delivery_time <= INT_WIDTH'(1);
            barrier       <= INT_WIDTH'(OUT_BARRIER);
            age_out       <= AGE_NULL;
            delivery_cnt  <= '0;
            out           <= 1'b0;
            spike_count   <= '0;
        end else if (cmd == CMD_CLEAR) begin
            for (int unsigned i = 0; i < INPUTS_COUNT; i++) begin
                age[i] <= AGE_NULL;
            end
            age_out      <= AGE_NULL;
            delivery_cnt <= '0;
            out          <= 1'b0;
            spike_count  <= '0;
        end else if (cmd == '0) begin
            for (int unsigned i = 0; i < INPUTS_COUNT; i++) begin
                age[i] <= age_adv[i];
            end
            age_out <= age_out_adv;
            if (delivery_cnt != '0) begin
                out <= (delivery_cnt == INT_WIDTH'(1));
                if (delivery_cnt == INT_WIDTH'(1) && spike_count != '1) begin
                    spike_count <= spike_count + 1'b1;
                end
                delivery_cnt <= delivery_cnt - 1'b1;
            end else begin
                out <= 1'b0;
                if (fire) begin
                    age_out <= '0;
                    if (delivery_time == '0) begin
                        out <= 1'b1;
                        if (spike_count != '1) begin
                            spike_count <= spike_count + 1'b1;
                        end
                    end else begin
                        delivery_cnt <= delivery_time;
                    end
                end
            end
        end else if (addr == ADDR_WIDTH'(NEURON_ID)) begin
            for (int unsigned i = 0; i < INPUTS_COUNT; i++) begin
                if (cmd == CMD_WIDTH'(i + 1)) begin
                    weight[i] <= cmd_arg;
                end
            end
            if (cmd == CMD_DELIV) begin
                delivery_time <= cmd_arg[INT_WIDTH-1:0];
            end
            if (cmd == CMD_BIAS) begin
                bias <= cmd_arg;
            end
            if (cmd == CMD_BARRIER) begin
                barrier <= cmd_arg[INT_WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_spiking_neuron_nin.sv
// Bench for spiking_neuron_nin: directed vector table, saturation run, and
// randomized traffic against an arithmetic reference model.
module tb_spiking_neuron_nin;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  addr = '0;
    logic [7:0]  cmd = '0;
    logic [15:0] cmd_arg = '0;
    logic [3:0]  in_bus = '0;
    logic        out;
    logic [7:0]  spike_count;

    always #5 clk = ~clk;

    spiking_neuron_nin #(
        .NEURON_ID(0),
        .INPUTS_COUNT(4),
        .ADDR_WIDTH(8),
        .CMD_WIDTH(8),
        .INT_WIDTH(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .addr(addr),
        .cmd(cmd),
        .cmd_arg(cmd_arg),
        .in_bus(in_bus),
        .out(out),
        .spike_count(spike_count)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state, plain integers.
    int m_w[4];
    int m_bias, m_dt, m_bar, m_age_out, m_dcnt, m_out, m_cnt;
    int m_age[4];
    int kern_tab[5] = '{178, 255, 153, 76, 25};

    function automatic int kern(input int a);
        return (a >= 0 && a <= 4) ? kern_tab[a] : 0;
    endfunction

    function automatic int adv(input int a);
        return (a < 4) ? a + 1 : 15;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 4; i++) m_age[i] = 15;
        m_age_out = 15;
        m_dcnt = 0;
        m_out = 0;
        m_cnt = 0;
    endtask

    task automatic m_spike();
        m_out = 1;
        if (m_cnt < 255) m_cnt = m_cnt + 1;
    endtask

    task automatic model_step(input bit r, input logic [7:0] a, input logic [7:0] c,
                              input logic [15:0] arg, input logic [3:0] ib);
        longint acc;
        int norm;
        if (r) begin
            for (int i = 0; i < 4; i++) m_w[i] = 255 / 4;
            m_bias = 0;
            m_dt = 1;
            m_bar = 127;
            m_clear();
        end else if (c == 8'd253) begin
            m_clear();
        end else if (c == 8'd0) begin
            m_age_out = adv(m_age_out);
            for (int i = 0; i < 4; i++) m_age[i] = ib[i] ? 0 : adv(m_age[i]);
            if (m_dcnt != 0) begin
                m_out = 0;
                if (m_dcnt == 1) m_spike();
                m_dcnt = m_dcnt - 1;
            end else begin
                m_out = 0;
                acc = longint'(m_bias) * 256 - longint'(kern(m_age_out)) * (255 * 4);
                for (int i = 0; i < 4; i++) acc += longint'(kern(m_age[i])) * m_w[i];
                if (acc < 0) norm = 0;
                else if (acc / 256 > 255) norm = 255;
                else norm = int'(acc / 256);
                if (norm > m_bar) begin
                    m_age_out = 0;
                    if (m_dt == 0) m_spike();
                    else m_dcnt = m_dt;
                end
            end
        end else if (a == 8'd0) begin
            if (c >= 1 && c <= 4) m_w[c - 1] = int'($signed(arg));
            else if (c == 8'd5) m_dt = int'(arg[7:0]);
            else if (c == 8'd6) m_bias = int'($signed(arg));
            else if (c == 8'd7) m_bar = int'(arg[7:0]);
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply(input bit r, input logic [7:0] a, input logic [7:0] c,
                         input logic [15:0] arg, input logic [3:0] ib);
        @(negedge clk);
        rst = r;
        addr = a;
        cmd = c;
        cmd_arg = arg;
        in_bus = ib;
        @(posedge clk);
        model_step(r, a, c, arg, ib);
        #1;
    endtask

    typedef struct {
        bit          r;
        logic [7:0]  a;
        logic [7:0]  c;
        logic [15:0] arg;
        logic [3:0]  ib;
        int          exp_out;
        int          exp_cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic v(input bit r, input logic [7:0] a, input logic [7:0] c,
                     input logic [15:0] arg, input logic [3:0] ib,
                     input int eo, input int ec);
        vec_t x;
        x.r = r; x.a = a; x.c = c; x.arg = arg; x.ib = ib;
        x.exp_out = eo; x.exp_cnt = ec;
        tbl.push_back(x);
    endtask

    initial begin
        // reset + default-weight tick: norm 43, no fire
        v(1, 0, 0, 16'd0,    4'b0000, 0, 0);
        v(0, 0, 0, 16'd0,    4'b0001, 0, 0);
        // w0 = 1024, delivery_time 1: fire, pulse next tick, no refire
        v(1, 0, 0, 16'd0,    4'b0000, 0, 0);
        v(0, 0, 1, 16'd1024, 4'b0000, 0, 0);
        v(0, 0, 0, 16'd0,    4'b0001, 0, 0);
        v(0, 0, 0, 16'd0,    4'b0000, 1, 1);
        v(0, 0, 0, 16'd0,    4'b0000, 0, 1);
        // delivery_time 0, bias +200 fires same tick; bias -200 does not
        v(1, 0, 0, 16'd0,    4'b0000, 0, 0);
        v(0, 0, 5, 16'd0,    4'b0000, 0, 0);
        v(0, 0, 6, 16'd200,  4'b0000, 0, 0);
        v(0, 0, 0, 16'd0,    4'b0000, 1, 1);
        v(0, 0, 6, 16'hFF38, 4'b0000, 1, 1);
        v(0, 0, 0, 16'd0,    4'b0000, 0, 1);
        // barrier 250 holds, barrier 199 fires (strictly greater)
        v(1, 0, 0, 16'd0,    4'b0000, 0, 0);
        v(0, 0, 5, 16'd0,    4'b0000, 0, 0);
        v(0, 0, 6, 16'd200,  4'b0000, 0, 0);
        v(0, 0, 7, 16'd250,  4'b0000, 0, 0);
        v(0, 0, 0, 16'd0,    4'b0000, 0, 0);
        v(0, 0, 7, 16'd199,  4'b0000, 0, 0);
        v(0, 0, 0, 16'd0,    4'b0000, 1, 1);
        // wrong address: weight stays 63
        v(1, 0, 0, 16'd0,    4'b0000, 0, 0);
        v(0, 5, 1, 16'd1024, 4'b0000, 0, 0);
        v(0, 0, 0, 16'd0,    4'b0001, 0, 0);
        // CLEAR during a 3-tick delivery cancels it; config survives
        v(1, 0, 0, 16'd0,    4'b0000, 0, 0);
        v(0, 0, 1, 16'd1024, 4'b0000, 0, 0);
        v(0, 0, 5, 16'd3,    4'b0000, 0, 0);
        v(0, 0, 0, 16'd0,    4'b0001, 0, 0);
        v(0, 7, 253, 16'd0,  4'b0000, 0, 0);
        v(0, 0, 0, 16'd0,    4'b0000, 0, 0);
        v(0, 0, 0, 16'd0,    4'b0000, 0, 0);
        v(0, 0, 0, 16'd0,    4'b0000, 0, 0);
        v(0, 0, 0, 16'd0,    4'b0000, 0, 0);
        v(0, 0, 0, 16'd0,    4'b0001, 0, 0);
        v(0, 0, 0, 16'd0,    4'b0000, 0, 0);
        v(0, 0, 0, 16'd0,    4'b0000, 0, 0);
        v(0, 0, 0, 16'd0,    4'b0000, 1, 1);
        // reset mid-delivery restores defaults
        v(0, 0, 0, 16'd0,    4'b0001, 0, 1);
        v(1, 0, 0, 16'd0,    4'b0000, 0, 0);
        v(0, 0, 0, 16'd0,    4'b0001, 0, 0);
        v(0, 0, 0, 16'd0,    4'b0000, 0, 0);
        v(0, 0, 0, 16'd0,    4'b0000, 0, 0);
        v(0, 0, 0, 16'd0,    4'b0000, 0, 0);
        v(0, 0, 0, 16'd0,    4'b0000, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].r, tbl[i].a, tbl[i].c, tbl[i].arg, tbl[i].ib);
            check($sformatf("vec%0d_out", i), int'(out), tbl[i].exp_out);
            check($sformatf("vec%0d_count", i), int'(spike_count), tbl[i].exp_cnt);
        end

        // Saturation: huge bias fires on every tick with delivery_time 0
        apply(1, 0, 0, 16'd0, 4'b0000);
        apply(0, 0, 5, 16'd0, 4'b0000);
        apply(0, 0, 6, 16'h7FFF, 4'b0000);
        for (int i = 0; i < 300; i++) begin
            apply(0, 0, 0, 16'd0, 4'b0000);
            check($sformatf("sat%0d_out", i), int'(out), 1);
            check($sformatf("sat%0d_count", i), int'(spike_count), (i + 1 < 255) ? i + 1 : 255);
        end
        // pulse held across a config cycle, cleared on next CLEAR
        apply(0, 0, 7, 16'd255, 4'b0000);
        check("sat_hold_out", int'(out), 1);
        apply(0, 9, 253, 16'd0, 4'b0000);
        check("sat_clear_out", int'(out), 0);
        check("sat_clear_count", int'(spike_count), 0);

        // Randomized traffic against the model
        apply(1, 0, 0, 16'd0, 4'b0000);
        for (int n = 0; n < 4000; n++) begin
            bit          r;
            logic [7:0]  a, c;
            logic [15:0] arg;
            logic [3:0]  ib;
            int          p;
            r   = ($urandom_range(0, 299) == 0);
            a   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
            ib  = 4'($urandom);
            arg = 16'($urandom);
            p   = $urandom_range(0, 99);
            if (p < 62) begin
                c = 8'd0;
            end else if (p < 70) begin
                c = 8'($urandom_range(1, 4));
                arg = 16'($urandom_range(0, 2400)) - 16'd1200;
            end else if (p < 76) begin
                c = 8'd5;
                arg = {arg[15:8], 8'($urandom_range(0, 4))};
            end else if (p < 82) begin
                c = 8'd6;
                arg = 16'($urandom_range(0, 600)) - 16'd300;
            end else if (p < 88) begin
                c = 8'd7;
            end else if (p < 91) begin
                c = 8'd253;
            end else begin
                c = 8'($urandom_range(8, 255));
                if (c == 8'd253) c = 8'd254;
            end
            apply(r, a, c, arg, ib);
            check($sformatf("rnd%0d_out", n), int'(out), m_out);
            check($sformatf("rnd%0d_count", n), int'(spike_count), m_cnt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spiking_neuron_nin.md
# spiking_neuron_nin

N-input generalisation of the 2-input spiking neuron used in the annealing spike network. It uses the same command bus (addr/cmd/cmd_arg) for weight, bias and delivery configuration. It adds three things the 2-input neuron lacks: a configurable input count, a runtime-settable firing barrier, and a saturating output spike counter that the annealer reads for fitness scoring. It advances one simulation step per `cmd == 0` cycle.

## Interface
- NEURON_ID, 0: address this neuron answers to.
- INPUTS_COUNT, 4: number of synaptic inputs (1..16).
- ADDR_WIDTH, 8: address bus width.
- CMD_WIDTH, 8: command width. Requires INPUTS_COUNT+3 < 2^CMD_WIDTH-3.
- INT_WIDTH, 8: base integer width. Weights are signed fixed point, where 2^INT_WIDTH = 1.0.
- OUT_BARRIER, INT_MAX/2 (floor): reset value of the firing barrier.
- COMPENSATION_WEIGHT, INT_MAX*INPUTS_COUNT: self-inhibition weight applied after a spike.
- clk  in  1  clock. All state changes on the rising edge.
- rst  in  1  synchronous, active-high reset. Has priority over every command.
- addr  in  ADDR_WIDTH  target neuron address for configuration commands.
- cmd  in  CMD_WIDTH  command. 0 means a simulation tick.
- cmd_arg  in  2*INT_WIDTH  command argument, interpreted as signed.
- in_bus  in  INPUTS_COUNT  input spikes, sampled only on ticks.
- out  out  1  output spike, registered.
- spike_count  out  INT_WIDTH  number of output spikes since reset/CLEAR. Saturates at 2^INT_WIDTH-1.

## Operation
- Constants: INT_MAX = 2^INT_WIDTH-1.
- Kernel k(age), integer floor of INT_MAX×{0.7, 1.0, 0.6, 0.3, 0.1} for age 0..4, and 0 for any other age. For INT_WIDTH=8 this is 178, 255, 153, 76, 25.
- Reset values: every weight w[i] = floor(INT_MAX/INPUTS_COUNT); bias = 0; delivery_time = 1; barrier = OUT_BARRIER; every age[i] = 15 (NULL); age_out = 15; delivery_cnt = 0; out = 0; spike_count = 0.
- Configuration commands take effect only when addr == NEURON_ID, except CLEAR:
  - 1..INPUTS_COUNT: w[cmd-1] = cmd_arg.
  - INPUTS_COUNT+1: delivery_time = cmd_arg[INT_WIDTH-1:0].
  - INPUTS_COUNT+2: bias = cmd_arg.
  - INPUTS_COUNT+3: barrier = cmd_arg[INT_WIDTH-1:0].
  - 2^CMD_WIDTH-3 (CLEAR, broadcast, addr ignored): ages, age_out, delivery_cnt, out and spike_count return to their reset values. Weights, bias, delivery_time and barrier are kept.
  - Any other nonzero cmd: no operation.
- Non-tick cycles leave out, the ages and the counters unchanged.
- Tick (cmd == 0), evaluated in this order within one cycle:
  1. Advance ages. age_out becomes age_out+1 if it is below 4, else 15. Each age[i] becomes 0 if in_bus[i]; otherwise age[i]+1 if it is below 4, else 15.
  2. If delivery_cnt != 0: no evaluation. If delivery_cnt == 1, out = 1 and spike_count increments with saturation. Then delivery_cnt decrements.
  3. Otherwise, out = 0 and the neuron evaluates:
     - acc = −k(age_out)·COMPENSATION_WEIGHT + bias·2^INT_WIDTH + Σ k(age[i])·w[i], computed with the updated ages from step 1.
     - acc is signed with width 3*INT_WIDTH + clog2(INPUTS_COUNT+2) + 1, and must never wrap.
     - norm = 0 if acc < 0; INT_MAX if (acc >>> INT_WIDTH) > INT_MAX; otherwise acc[2*INT_WIDTH-1:INT_WIDTH].
     - If norm > barrier (strictly greater), the neuron fires:
       - age_out = 0.
       - If delivery_time == 0: out = 1 and spike_count increments, both in this same tick.
       - Otherwise delivery_cnt = delivery_time.
- Changing delivery_time while delivery_cnt != 0 does not alter the pending countdown.
- A CLEAR during delivery cancels the pending spike.

## Timing
- out and spike_count are registered and change only at the edge that ends a tick, a CLEAR or a reset.
- Fire-to-out latency: 0 ticks when delivery_time == 0; otherwise exactly delivery_time ticks after the evaluating tick.
- The out pulse lasts until the next tick, so it is one tick wide. Interleaved configuration cycles stretch it in clocks but not in ticks.
- While a delivery is pending, no new spike can be scheduled.
- Asserting rst during any cycle, including mid-delivery, gives out = 0 and all reset values after that edge.

## Test plan
- Reset, then one tick with in_bus = 4'b0001: norm = 178·63>>8 = 43, which is not above 127, so out stays 0 and spike_count stays 0.
- Set w[0] = 1024 (cmd 1, addr = NEURON_ID), then tick with in_bus = 4'b0001: norm saturates to 255 and the neuron fires. out = 0 on that tick, out = 1 on the next tick, out = 0 on the tick after, and spike_count = 1. The third tick has acc = 153·1024 − 153·1020 = 612, so norm = 2 and there is no refire.
- delivery_time = 0 (cmd 5), bias = 200 (cmd 6), tick with in_bus = 0: out = 1 on the same tick. Repeat with bias = −200: norm = 0 and no spike.
- Barrier = 250 (cmd 7), bias = 200, tick: no fire. Barrier = 199, tick: fire.
- Configuration cmd 1 with addr ≠ NEURON_ID: weight unchanged. CLEAR (253) with any addr, issued while delivery_cnt = 3: no out pulse follows and spike_count = 0; w[0] still 1024.
- rst asserted mid-delivery: out = 0, weights = 63, spike_count = 0 after the edge. 256 spikes with delivery_time = 0 leave spike_count at 255.
